// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port synchronous SRAM between the rv32 fetch and data ports.
// Latency: fetch is fully pipelined (address in cycle N, instruction in N+1); a data access costs 2 stall cycles.
// Backpressure: data wins the port, and the core is frozen through `stall` while fetch is displaced.
module rv32_mem_arbiter #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_fetch,
  output logic [31:0]      code_fetch,
  input  logic             data_enable,
  input  logic             data_read,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_store,
  output logic [31:0]      data_fetch,
  output logic             stall,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  // PRIME: first fetch after reset, STREAM: pipelined fetch or data issue,
  // DRSP: data response cycle with the fetch reissued underneath it.
  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRSP   = 2'd2
  } state_t;

  state_t           state;
  logic             data_done;  // current EX request already serviced
  logic             rd_pend;    // access in flight is a load
  logic [31:0]      code_hold;  // last instruction seen, replayed while stalled
  logic [31:0]      data_hold;  // last load result, held for the core
  logic [CNT_W-1:0] stall_ctr;
  logic             issue_data;

  assign stall_cnt = stall_ctr;

  // Port steering and core-facing outputs; stall never depends on mem_rdata.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc_fetch;
    mem_wdata  = 32'h0;
    stall      = 1'b1;
    code_fetch = code_hold;
    data_fetch = data_hold;
    issue_data = 1'b0;
    if (rst) begin
      code_fetch = NOP_WORD;
      data_fetch = 32'h0;
    end else begin
      case (state)
        ST_PRIME: begin
          mem_en = 1'b1;
        end
        ST_STREAM: begin
          code_fetch = mem_rdata;
          mem_en     = 1'b1;
          if (data_enable && !data_done) begin
            // Data displaces this cycle's fetch; the held PC refetches later.
            issue_data = 1'b1;
            mem_addr   = data_addr;
            mem_we     = !data_read;
            mem_wdata  = data_read ? 32'h0 : data_store;
          end else begin
            stall = 1'b0;
          end
        end
        ST_DRSP: begin
          mem_en = 1'b1;
          if (rd_pend) begin
            data_fetch = mem_rdata;
          end
        end
        default: begin
          mem_en = 1'b0;
        end
      endcase
    end
  end

  // State sequencing, hold registers, request bookkeeping and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PRIME;
      data_done <= 1'b0;
      rd_pend   <= 1'b0;
      code_hold <= NOP_WORD;
      data_hold <= 32'h0;
      stall_ctr <= '0;
    end else begin
      if (stall) begin
        stall_ctr <= stall_ctr + 1'b1;
      end else begin
        // The EX instruction moved on, so a new request may be accepted.
        data_done <= 1'b0;
      end
      case (state)
        ST_PRIME: begin
          state <= ST_STREAM;
        end
        ST_STREAM: begin
          code_hold <= mem_rdata;
          if (issue_data) begin
            data_done <= 1'b1;
            rd_pend   <= data_read;
            state     <= ST_DRSP;
          end
        end
        ST_DRSP: begin
          if (rd_pend) begin
            data_hold <= mem_rdata;
          end
          state <= ST_STREAM;
        end
        default: begin
          state <= ST_PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed self-checking bench for rv32_mem_arbiter with a synchronous SRAM model.
// Drives inputs just after each rising edge and checks outputs mid-cycle.
// Counter is built 4 bits wide so the wrap case is reachable quickly.
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_fetch;
  logic [31:0] code_fetch;
  logic        data_enable;
  logic        data_read;
  logic [31:0] data_addr;
  logic [31:0] data_store;
  logic [31:0] data_fetch;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad   = 0;
  int issues;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.CNT_W(4), .NOP_WORD(32'h0000_0013)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_fetch   (pc_fetch),
    .code_fetch (code_fetch),
    .data_enable(data_enable),
    .data_read  (data_read),
    .data_addr  (data_addr),
    .data_store (data_store),
    .data_fetch (data_fetch),
    .stall      (stall),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_cnt  (stall_cnt)
  );

  // Single-port synchronous SRAM: write on the issue edge, read data next cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[64]  = 32'hDEAD_BEEF;  // 0x100
    mem[128] = 32'h0000_0000;  // 0x200
    mem_rdata   = 32'h0;
    rst         = 1'b1;
    pc_fetch    = 32'h0;
    data_enable = 1'b0;
    data_read   = 1'b0;
    data_addr   = 32'h0;
    data_store  = 32'h0;

    // Reset held for 3 cycles
    #1;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_code", code_fetch, 32'h0000_0013);
    chk("rst_data", data_fetch, 32'h0);
    tick();
    tick();
    tick();
    chk("rst3_mem_en", 32'(mem_en), 32'd0);
    chk("rst3_mem_we", 32'(mem_we), 32'd0);
    chk("rst3_code", code_fetch, 32'h0000_0013);
    chk("rst3_cnt", 32'(stall_cnt), 32'd0);

    // A: PRIME
    tick(); rst = 1'b0; pc_fetch = 32'h0; #1;
    chk("prime_en", 32'(mem_en), 32'd1);
    chk("prime_addr", mem_addr, 32'h0);
    chk("prime_stall", 32'(stall), 32'd1);
    chk("prime_code", code_fetch, 32'h0000_0013);

    // B..E: streaming fetch
    tick(); pc_fetch = 32'h4; #1;
    chk("s0_stall", 32'(stall), 32'd0);
    chk("s0_code", code_fetch, 32'hC0DE_0000);
    chk("s0_addr", mem_addr, 32'h4);
    tick(); pc_fetch = 32'h8; #1;
    chk("s1_stall", 32'(stall), 32'd0);
    chk("s1_code", code_fetch, 32'hC0DE_0001);
    tick(); pc_fetch = 32'hC; #1;
    chk("s2_stall", 32'(stall), 32'd0);
    chk("s2_code", code_fetch, 32'hC0DE_0002);
    tick(); pc_fetch = 32'h10; #1;
    chk("s3_code", code_fetch, 32'hC0DE_0003);
    chk("s3_cnt", 32'(stall_cnt), 32'd1);

    // F: load issue from 0x100
    tick(); pc_fetch = 32'h14; data_enable = 1'b1; data_read = 1'b1; data_addr = 32'h100; #1;
    chk("ld_iss_stall", 32'(stall), 32'd1);
    chk("ld_iss_addr", mem_addr, 32'h100);
    chk("ld_iss_we", 32'(mem_we), 32'd0);
    chk("ld_iss_wdata", mem_wdata, 32'h0);
    chk("ld_iss_code", code_fetch, 32'hC0DE_0004);
    // G: DRSP
    tick(); #1;
    chk("ld_rsp_stall", 32'(stall), 32'd1);
    chk("ld_rsp_data", data_fetch, 32'hDEAD_BEEF);
    chk("ld_rsp_addr", mem_addr, 32'h14);
    chk("ld_rsp_code", code_fetch, 32'hC0DE_0004);
    chk("ld_rsp_cnt", 32'(stall_cnt), 32'd2);
    // H: request still held, must not be reissued
    tick(); pc_fetch = 32'h18; #1;
    chk("ld_held_stall", 32'(stall), 32'd0);
    chk("ld_held_addr", mem_addr, 32'h18);
    chk("ld_held_code", code_fetch, 32'hC0DE_0005);
    chk("ld_held_data", data_fetch, 32'hDEAD_BEEF);
    // I
    tick(); data_enable = 1'b0; pc_fetch = 32'h1C; #1;
    chk("ld_after_code", code_fetch, 32'hC0DE_0006);
    chk("ld_after_data", data_fetch, 32'hDEAD_BEEF);

    // J: store 0x12345678 to 0x200
    tick(); pc_fetch = 32'h20; data_enable = 1'b1; data_read = 1'b0;
    data_addr = 32'h200; data_store = 32'h1234_5678; #1;
    chk("st_iss_we", 32'(mem_we), 32'd1);
    chk("st_iss_wdata", mem_wdata, 32'h1234_5678);
    chk("st_iss_addr", mem_addr, 32'h200);
    chk("st_iss_stall", 32'(stall), 32'd1);
    // K: DRSP of the store
    tick(); #1;
    chk("st_rsp_we", 32'(mem_we), 32'd0);
    chk("st_rsp_wdata", mem_wdata, 32'h0);
    chk("st_rsp_stall", 32'(stall), 32'd1);
    chk("st_rsp_data", data_fetch, 32'hDEAD_BEEF);
    // L: one unstalled cycle
    tick(); pc_fetch = 32'h24; #1;
    chk("st_gap_stall", 32'(stall), 32'd0);
    chk("st_gap_we", 32'(mem_we), 32'd0);
    chk("st_gap_code", code_fetch, 32'hC0DE_0008);
    // M: load back from 0x200
    tick(); pc_fetch = 32'h28; data_read = 1'b1; #1;
    chk("ld2_iss_stall", 32'(stall), 32'd1);
    chk("ld2_iss_we", 32'(mem_we), 32'd0);
    chk("ld2_iss_addr", mem_addr, 32'h200);
    // N
    tick(); #1;
    chk("ld2_rsp_data", data_fetch, 32'h1234_5678);
    // O
    tick(); data_enable = 1'b0; pc_fetch = 32'h2C; #1;
    chk("ld2_after_stall", 32'(stall), 32'd0);
    chk("ld2_after_code", code_fetch, 32'hC0DE_000A);
    chk("ld2_after_data", data_fetch, 32'h1234_5678);
    chk("ld2_after_cnt", 32'(stall_cnt), 32'd7);

    // Back-to-back: request held 6 cycles -> issues at cycles 0 and 3
    issues = 0;
    for (int k = 0; k < 6; k++) begin
      tick(); pc_fetch = 32'h30; data_enable = 1'b1; data_read = 1'b1; data_addr = 32'h100; #1;
      chk($sformatf("b2b_stall_%0d", k), 32'(stall), (k % 3 == 2) ? 32'd0 : 32'd1);
      if (mem_en && mem_addr == 32'h100) issues++;
    end
    chk("b2b_issues", 32'(issues), 32'd2);
    // P
    tick(); data_enable = 1'b0; #1;
    chk("b2b_after_stall", 32'(stall), 32'd0);
    chk("b2b_cnt", 32'(stall_cnt), 32'd11);

    // Reset mid-load: Q issue, R DRSP with rst
    tick(); data_enable = 1'b1; data_read = 1'b1; data_addr = 32'h100; #1;
    chk("rml_iss_addr", mem_addr, 32'h100);
    tick(); rst = 1'b1; #1;
    chk("rml_data", data_fetch, 32'h0);
    chk("rml_mem_en", 32'(mem_en), 32'd0);
    chk("rml_stall", 32'(stall), 32'd1);
    // S: PRIME after reset
    tick(); rst = 1'b0; data_enable = 1'b0; pc_fetch = 32'h40; #1;
    chk("rml_prime_addr", mem_addr, 32'h40);
    chk("rml_prime_stall", 32'(stall), 32'd1);
    chk("rml_prime_code", code_fetch, 32'h0000_0013);
    chk("rml_prime_data", data_fetch, 32'h0);
    chk("rml_prime_cnt", 32'(stall_cnt), 32'd0);

    // Counter wrap: PRIME plus 16 data stalls = 17 stall cycles -> 1
    for (int k = 0; k < 24; k++) begin
      tick(); data_enable = 1'b1; data_read = 1'b1; data_addr = 32'h100; #1;
      chk($sformatf("wrap_stall_%0d", k), 32'(stall), (k % 3 == 2) ? 32'd0 : 32'd1);
    end
    tick(); data_enable = 1'b0; #1;
    chk("wrap_stall_end", 32'(stall), 32'd0);
    chk("wrap_cnt", 32'(stall_cnt), 32'd1);
    chk("wrap_data", data_fetch, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
